fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
Fetch stage that sits directly downstream of the program counter. It presents the current PC to the instruction cache and waits for ihit. Each returned instruction, with its PC+4, goes into a DEPTH-entry FIFO feeding decode. It drives pc_en back to the PC so the PC advances only when a fetch is accepted, and it discards all fetched state on a redirect (flush).

Parameters:
DEPTH, 2, FIFO entries (power of two, >=2)
RECOVER_CYCLES, 1, cycles iREN is held low after a flush before fetching resumes (>=1)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
imemaddr  in  32  current PC from program counter
pc_plus_4  in  32  PC+4 from program counter
pc_en  out  1  PC advance/load enable to program counter
iREN  out  1  instruction cache read request
iaddr  out  32  instruction cache address (= imemaddr)
ihit  in  1  cache hit; iload valid this cycle
iload  in  32  instruction word from cache
flush  in  1  redirect from execute (branch/jump taken); PC loads target this cycle
dec_ready  in  1  decode accepts head entry this cycle
dec_valid  out  1  FIFO head valid
dec_instr  out  32  head instruction; 0 when empty
dec_pc4  out  32  head PC+4; 0 when empty

Behaviour:
- Reset: RST high at a rising edge clears count, head/tail pointers and recover counter, and sets state RUN. Reset has priority over every other input, including mid-fetch and mid-recover.
- Outputs while RST is sampled and the cycle after: iREN=0, pc_en=0, dec_valid=0, dec_instr=0, dec_pc4=0.
- iaddr = imemaddr combinationally, always.
- FSM states: RUN, FULL, RECOVER.
- RUN:
  - iREN=1 when count<DEPTH.
  - Go to FULL when a push makes count==DEPTH without a simultaneous pop.
- FULL:
  - iREN=0.
  - Return to RUN on the cycle after any pop.
- RECOVER:
  - iREN=0. Counter loads RECOVER_CYCLES on flush and decrements each cycle.
  - Return to RUN when the counter reaches 0.
- Push = iREN & ihit & !flush. Writes {iload, pc_plus_4} at tail, tail++ (wraps mod DEPTH).
- Pop = dec_valid & dec_ready & !flush. head++ (wraps mod DEPTH).
- count update: count+1 on push only, count-1 on pop only, unchanged on simultaneous push and pop.
- pc_en = push | flush. The PC therefore holds on a cache miss, when FULL, and in RECOVER.
- flush, from any state except reset:
  - Clears count and head/tail next cycle.
  - Discards any ihit and dec_ready seen in the same cycle.
  - Enters RECOVER.
  - Asserts pc_en so the PC loads the redirect target.
- flush while already in RECOVER reloads the counter.
- dec_valid = (count!=0). Head data stays stable while dec_valid=1 and dec_ready=0.
- Read-before-write: data pushed this cycle is visible at the head no earlier than the next cycle (1-cycle fetch-to-decode latency minimum).
- Cache is blocking: iaddr is held stable while iREN=1 and ihit=0, because pc_en=0.
- Assertions: count<=DEPTH; no push when count==DEPTH; no pop when count==0.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {RUN, FULL, RECOVER}
  - fetch_entry_t packed struct {word_t instr; word_t pc4;}
- A new fetch_if interface carries the decode-side signals (dec_valid, dec_ready, dec_instr, dec_pc4), with modports fb and dec.
- One sub-module, sync_fifo: parameterized DEPTH and entry type, push/pop/flush, count/full/empty, synchronous active-high reset. fetch_buffer wraps it with the FSM and pc_en logic.

Test Plan:
- Reset then 3 cycles with ihit=1, dec_ready=1, imemaddr 0,4,8 -> pc_en=1 each cycle; dec_pc4 sequence 4,8,12 starting one cycle after the first ihit.
- ihit held 0 for 4 cycles at imemaddr=0x10 -> iREN=1, pc_en=0, iaddr=0x10 stable; on ihit, instruction 0x8C220004 appears at head next cycle.
- dec_ready=0, ihit=1 continuously, DEPTH=2 -> two pushes, state FULL, iREN=0, pc_en=0. One dec_ready pulse -> one pop, iREN=1 next cycle.
- flush with count=2 and ihit=1 in the same cycle -> pc_en=1, no push, dec_valid=0 next cycle, iREN=0 for exactly RECOVER_CYCLES cycles, then fetch of the new imemaddr.
- RST asserted while FULL and while in RECOVER -> next cycle all outputs 0, count=0. Deassert -> iREN=1 the following cycle.
- Simultaneous push and pop at count=1 -> count stays 1, head advances to the newly pushed entry in order.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the fetch FIFO entry.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN,
        FULL,
        RECOVER
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Decode-side handshake of the fetch buffer: head entry plus valid/ready.
interface fetch_if;
    import cpu_types_pkg::*;

    logic  dec_valid;
    logic  dec_ready;
    word_t dec_instr;
    word_t dec_pc4;

    modport fb  (output dec_valid, output dec_instr, output dec_pc4, input dec_ready);
    modport dec (input dec_valid, input dec_instr, input dec_pc4, output dec_ready);
endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head data is read combinationally.
module sync_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [63:0]
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  T                       i_wdata,
    output T                       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_tail] <= i_wdata;
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: requests the current PC from the I-cache, queues {instr, pc+4}
// for decode and throttles the PC via pc_en; a flush discards all fetched state.
module fetch_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t imemaddr,
    input  word_t pc_plus_4,
    output logic  pc_en,
    output logic  iREN,
    output word_t iaddr,
    input  logic  ihit,
    input  word_t iload,
    input  logic  flush,
    input  logic  dec_ready,
    output logic  dec_valid,
    output word_t dec_instr,
    output word_t dec_pc4
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int RCW = $clog2(RECOVER_CYCLES + 1);

    fetch_state_t   r_state, w_state_nxt;
    logic [RCW-1:0] r_rec_cnt, w_rec_nxt;
    logic           r_rst_q;

    logic           w_blank, w_ren, w_push, w_pop, w_valid, w_full, w_empty;
    logic [CW-1:0]  w_count;
    fetch_entry_t   w_head, w_wdata;

    fetch_if u_dec_if ();

    // Outputs stay quiet while reset is sampled and for one cycle after.
    assign w_blank = RST | r_rst_q;
    assign w_ren   = (r_state == RUN) & ~w_full & ~w_blank;
    assign w_push  = w_ren & ihit & ~flush;
    assign w_valid = ~w_empty & ~w_blank;
    assign w_pop   = w_valid & u_dec_if.dec_ready & ~flush;
    assign w_wdata = '{instr: iload, pc4: pc_plus_4};

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        r_rst_q <= RST;
        if (RST) begin
            r_state   <= RUN;
            r_rec_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rec_cnt <= w_rec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rec_nxt   = r_rec_cnt;
        unique case (r_state)
            RUN:     if (w_push && !w_pop && (w_count == CW'(DEPTH - 1))) w_state_nxt = FULL;
            FULL:    if (w_pop) w_state_nxt = RUN;
            RECOVER: begin
                w_rec_nxt = r_rec_cnt - RCW'(1);
                if (r_rec_cnt <= RCW'(1)) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
        if (flush) begin
            w_state_nxt = RECOVER;
            w_rec_nxt   = RCW'(RECOVER_CYCLES);
        end
    end

    assign u_dec_if.dec_ready = dec_ready;
    assign u_dec_if.dec_valid = w_valid;
    assign u_dec_if.dec_instr = w_valid ? w_head.instr : '0;
    assign u_dec_if.dec_pc4   = w_valid ? w_head.pc4   : '0;

    assign dec_valid = u_dec_if.dec_valid;
    assign dec_instr = u_dec_if.dec_instr;
    assign dec_pc4   = u_dec_if.dec_pc4;
    assign iREN      = w_ren;
    assign iaddr     = imemaddr;
    assign pc_en     = ~w_blank & (w_push | flush);

    a_count_range: assert property (@(posedge CLK) disable iff (RST) w_count <= CW'(DEPTH));
    a_no_ovf:      assert property (@(posedge CLK) disable iff (RST) !(w_push && w_full));
    a_no_udf:      assert property (@(posedge CLK) disable iff (RST) !(w_pop && w_empty));
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=2, RECOVER_CYCLES=1) with a decode-side scoreboard.
module tb_fetch_buffer;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    word_t imemaddr, pc_plus_4, iload, iaddr, dec_instr, dec_pc4;
    logic  pc_en, iREN, ihit, flush, dec_ready, dec_valid;

    int n_pass  = 0;
    int n_total = 0;
    fetch_entry_t q[$];

    fetch_buffer #(.DEPTH(2), .RECOVER_CYCLES(1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemaddr  (imemaddr),
        .pc_plus_4 (pc_plus_4),
        .pc_en     (pc_en),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .ihit      (ihit),
        .iload     (iload),
        .flush     (flush),
        .dec_ready (dec_ready),
        .dec_valid (dec_valid),
        .dec_instr (dec_instr),
        .dec_pc4   (dec_pc4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        else n_pass++;
    endtask

    // Monitor: every accepted head entry must match the oldest expected fetch.
    always @(negedge CLK) begin
        if (!RST && dec_valid && dec_ready && !flush) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got pc4=%h expected no entry", dec_pc4);
            end else begin
                fetch_entry_t e;
                e = q.pop_front();
                chk("sb_instr", dec_instr, e.instr);
                chk("sb_pc4", dec_pc4, e.pc4);
            end
        end
    end

    // One clock of stimulus with expected combinational outputs for that cycle.
    task automatic cyc(input logic ih, input word_t ld, input word_t pc, input logic dr,
                       input logic fl, input logic e_ren, input logic e_pcen,
                       input logic e_dv, input logic e_push);
        imemaddr = pc; pc_plus_4 = pc + 32'd4; ihit = ih; iload = ld;
        dec_ready = dr; flush = fl;
        @(negedge CLK);
        chk("iREN", iREN, e_ren);
        chk("pc_en", pc_en, e_pcen);
        chk("iaddr", iaddr, pc);
        chk("dec_valid", dec_valid, e_dv);
        if (!e_dv) begin
            chk("empty_instr", dec_instr, 32'd0);
            chk("empty_pc4", dec_pc4, 32'd0);
        end
        @(posedge CLK);
        if (fl) q.delete();
        if (e_push) q.push_back('{instr: ld, pc4: pc + 32'd4});
        #1;
    endtask

    task automatic do_reset(input logic ih, input logic dr);
        RST = 1'b1; ihit = ih; dec_ready = dr; flush = 1'b0;
        @(negedge CLK);
        chk("rst_iREN", iREN, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc4", dec_pc4, 32'd0);
        @(posedge CLK);
        q.delete();
        #1;
        RST = 1'b0;
        // Post-reset quiet cycle, even with a hit and ready offered.
        cyc(ih, 32'hDEAD_0000, imemaddr, dr, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST = 1'b1; imemaddr = '0; pc_plus_4 = 32'd4; ihit = 0; iload = '0;
        flush = 0; dec_ready = 0;
        @(posedge CLK); #1;
        do_reset(0, 1);

        // Streaming hits: pc4 4,8,12 appear one cycle after each hit.
        //  ih  load           pc        dr fl ren pcen dv push
        cyc(1, 32'h1000_0000, 32'h00, 1, 0, 1, 1, 0, 1);
        cyc(1, 32'h1000_0004, 32'h04, 1, 0, 1, 1, 1, 1);
        cyc(1, 32'h1000_0008, 32'h08, 1, 0, 1, 1, 1, 1);
        cyc(0, 32'h0,         32'h0C, 1, 0, 1, 0, 1, 0);

        // Blocking miss at 0x10: PC held, then hit lands at head next cycle.
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 32'h10, 1, 0, 1, 0, 0, 0);
        cyc(1, 32'h8C22_0004, 32'h10, 1, 0, 1, 1, 0, 1);
        cyc(0, 32'h0,         32'h14, 0, 0, 1, 0, 1, 0);
        chk("miss_head_instr", dec_instr, 32'h8C22_0004);
        cyc(0, 32'h0,         32'h14, 1, 0, 1, 0, 1, 0);

        // Fill to FULL with decode stalled, one pop releases fetch.
        cyc(1, 32'hA000_0018, 32'h18, 0, 0, 1, 1, 0, 1);
        cyc(1, 32'hA000_001C, 32'h1C, 0, 0, 1, 1, 1, 1);
        cyc(1, 32'hA000_0020, 32'h20, 0, 0, 0, 0, 1, 0);
        cyc(1, 32'hA000_0020, 32'h20, 1, 0, 0, 0, 1, 0);
        cyc(0, 32'h0,         32'h20, 0, 0, 1, 0, 1, 0);
        chk("full_head_pc4", dec_pc4, 32'h20);

        // Flush at count=2 with ihit and dec_ready: nothing pushed or popped.
        cyc(1, 32'hA000_0020, 32'h20,  0, 0, 1, 1, 1, 1);
        cyc(1, 32'hBAD0_0000, 32'h20,  1, 1, 0, 1, 1, 0);
        cyc(1, 32'hBAD0_0001, 32'h100, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'hC000_0100, 32'h100, 0, 0, 1, 1, 0, 1);
        cyc(0, 32'h0,         32'h104, 1, 0, 1, 0, 1, 0);

        // Flush in RUN discards the hit; second flush in RECOVER restarts the wait.
        cyc(1, 32'hBAD0_0002, 32'h104, 0, 1, 1, 1, 0, 0);
        cyc(1, 32'hBAD0_0003, 32'h200, 0, 1, 0, 1, 0, 0);
        cyc(1, 32'hBAD0_0004, 32'h200, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'hC000_0200, 32'h200, 0, 0, 1, 1, 0, 1);
        cyc(0, 32'h0,         32'h204, 1, 0, 1, 0, 1, 0);

        // Reset while FULL.
        cyc(1, 32'hD000_0300, 32'h300, 0, 0, 1, 1, 0, 1);
        cyc(1, 32'hD000_0304, 32'h304, 0, 0, 1, 1, 1, 1);
        cyc(1, 32'hD000_0308, 32'h308, 0, 0, 0, 0, 1, 0);
        do_reset(1, 1);
        cyc(0, 32'h0, 32'h308, 1, 0, 1, 0, 0, 0);

        // Reset while in RECOVER.
        cyc(0, 32'h0, 32'h308, 0, 1, 1, 1, 0, 0);
        do_reset(0, 0);
        cyc(0, 32'h0, 32'h400, 0, 0, 1, 0, 0, 0);

        // Simultaneous push and pop at count=1 keeps order.
        cyc(1, 32'hE000_0400, 32'h400, 0, 0, 1, 1, 0, 1);
        cyc(1, 32'hE000_0404, 32'h404, 1, 0, 1, 1, 1, 1);
        cyc(0, 32'h0,         32'h408, 0, 0, 1, 0, 1, 0);
        chk("pp_head_pc4", dec_pc4, 32'h408);
        chk("pp_head_instr", dec_instr, 32'hE000_0404);
        cyc(0, 32'h0,         32'h408, 1, 0, 1, 0, 1, 0);
        cyc(0, 32'h0,         32'h408, 0, 0, 1, 0, 0, 0);

        chk("sb_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
